// File: rtl/ultrasonic_ranger_mc.sv
// Multi-channel HC-SR04 ranger: round-robin trigger slots, echo width measured in whole
// centimetres, per-channel timeout, IIR smoothing and a speaker note taken from channel 0.
module ultrasonic_ranger_mc #(
  parameter int N_CH        = 2,
  parameter int DIST_W      = 11,
  parameter int TRIG_CYC    = 1000,
  parameter int CM_CYC      = 5800,
  parameter int SLOT_CYC    = 6000000,
  parameter int RISE_TO_CYC = 100000,
  parameter int MAX_CM      = 400,
  parameter int FILT_SHIFT  = 2,
  parameter int NOTE_DIV    = 31
) (
  input  logic                     clk_100MHz,
  input  logic                     reset,
  input  logic [N_CH-1:0]          echo_in,
  output logic [N_CH-1:0]          trig_out,
  output logic [N_CH*DIST_W-1:0]   distance_cm,
  output logic [N_CH-1:0]          dist_valid,
  output logic [N_CH-1:0]          timeout,
  output logic [2:0]               active_ch,
  output logic [4:0]               speaker_note
);
  localparam int SLOT_W = $clog2(SLOT_CYC);
  localparam int PH_MAX = (TRIG_CYC > RISE_TO_CYC) ? TRIG_CYC : RISE_TO_CYC;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int CYC_W  = (CM_CYC > 1) ? $clog2(CM_CYC) : 1;

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;
  state_t state, state_nxt;

  logic [N_CH-1:0]   echo_s1, echo_s2, echo_d;
  logic [7:0]        echo_now_x, echo_prev_x;
  logic              rise, fall;
  logic [SLOT_W-1:0] slot_cnt;
  logic [PH_W-1:0]   ph_cnt;
  logic [CYC_W-1:0]  cyc;
  logic [DIST_W-1:0] cm_raw, cm_next;
  logic              wrap, rec_ok, rec_to;
  logic [N_CH-1:0]   primed;
  logic [DIST_W-1:0] cur_f, filt_new, note_q;
  logic              cur_primed;
  logic signed [DIST_W:0] diff, step, sum;
  logic [4:0]        note_calc;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      echo_s1 <= '0;
      echo_s2 <= '0;
      echo_d  <= '0;
    end else begin
      echo_s1 <= echo_in;
      echo_s2 <= echo_s1;
      echo_d  <= echo_s2;
    end
  end

  // Only the channel owning the current slot is observed.
  assign echo_now_x  = 8'(echo_s2);
  assign echo_prev_x = 8'(echo_d);
  assign rise = echo_now_x[active_ch] & ~echo_prev_x[active_ch];
  assign fall = ~echo_now_x[active_ch] & echo_prev_x[active_ch];

  assign wrap    = (cyc == CYC_W'(CM_CYC - 1));
  assign cm_next = cm_raw + DIST_W'(wrap);

  assign trig_out = (state == TRIG) ? N_CH'(8'd1 << active_ch) : '0;

  always_comb begin
    state_nxt = state;
    rec_ok    = 1'b0;
    rec_to    = 1'b0;
    case (state)
      IDLE: state_nxt = TRIG;
      TRIG: if (ph_cnt == PH_W'(TRIG_CYC - 1)) state_nxt = WAIT_RISE;
      WAIT_RISE: begin
        if (rise) state_nxt = MEASURE;
        else if (ph_cnt == PH_W'(RISE_TO_CYC - 1)) begin
          rec_to    = 1'b1;
          state_nxt = HOLDOFF;
        end
      end
      MEASURE: begin
        if (cm_next > DIST_W'(MAX_CM)) begin
          rec_to    = 1'b1;
          state_nxt = HOLDOFF;
        end else if (fall) begin
          rec_ok    = 1'b1;
          state_nxt = HOLDOFF;
        end
      end
      HOLDOFF: if (slot_cnt >= SLOT_W'(SLOT_CYC - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state     <= IDLE;
      active_ch <= '0;
      slot_cnt  <= '0;
      ph_cnt    <= '0;
      cyc       <= '0;
      cm_raw    <= '0;
    end else begin
      state    <= state_nxt;
      slot_cnt <= (state == IDLE) ? '0 : slot_cnt + SLOT_W'(1);
      ph_cnt   <= (state_nxt != state) ? '0 : ph_cnt + PH_W'(1);
      if (state != MEASURE) begin
        cyc    <= '0;
        cm_raw <= '0;
      end else begin
        cyc    <= wrap ? '0 : cyc + CYC_W'(1);
        cm_raw <= cm_next;
      end
      if (state == HOLDOFF && state_nxt == IDLE)
        active_ch <= (active_ch == 3'(N_CH - 1)) ? 3'd0 : active_ch + 3'd1;
    end
  end

  // Filter state lives in the distance register itself.
  always_comb begin
    cur_f      = '0;
    cur_primed = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (i == int'(active_ch)) begin
        cur_f      = distance_cm[i*DIST_W +: DIST_W];
        cur_primed = primed[i];
      end
    end
    diff     = $signed({1'b0, cm_next}) - $signed({1'b0, cur_f});
    step     = diff >>> FILT_SHIFT;
    sum      = $signed({1'b0, cur_f}) + step;
    filt_new = (FILT_SHIFT == 0 || !cur_primed) ? cm_next : sum[DIST_W-1:0];
  end

  always_comb begin
    note_q    = distance_cm[DIST_W-1:0] / DIST_W'(NOTE_DIV);
    note_calc = (note_q > DIST_W'(31)) ? 5'd31 : note_q[4:0];
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      distance_cm  <= '0;
      dist_valid   <= '0;
      timeout      <= '0;
      primed       <= '0;
      speaker_note <= '0;
    end else begin
      dist_valid   <= '0;
      speaker_note <= note_calc;
      for (int i = 0; i < N_CH; i++) begin
        if (i == int'(active_ch)) begin
          if (rec_ok) begin
            dist_valid[i] <= 1'b1;
            timeout[i]    <= 1'b0;
            primed[i]     <= 1'b1;
            distance_cm[i*DIST_W +: DIST_W] <= filt_new;
          end else if (rec_to) begin
            dist_valid[i] <= 1'b1;
            timeout[i]    <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: doc/ultrasonic_ranger_mc.md
Name: ultrasonic_ranger_mc

Overview:
Parametrised multi-channel successor to the single-sensor HC-SR04 distance meter. It triggers N_CH ultrasonic sensors round-robin, one per time slot, and measures each echo pulse directly in centimetres. Each channel has timeout detection, an optional IIR smoothing filter and a per-channel valid strobe. It also drives the speaker-note index from channel 0 and sits between the sensor pins and the display/audio logic.

Parameters:
N_CH, 2, number of sensor channels (1..8)
DIST_W, 11, width of each distance result
TRIG_CYC, 1000, trigger pulse length in clocks (10 us)
CM_CYC, 5800, clocks of echo per centimetre (58 us)
SLOT_CYC, 6000000, clocks per channel slot, measured from trigger rise (60 ms); must exceed TRIG_CYC+RISE_TO_CYC+(MAX_CM+1)*CM_CYC
RISE_TO_CYC, 100000, maximum clocks from trigger fall to echo rise
MAX_CM, 400, largest valid distance
FILT_SHIFT, 2, IIR smoothing shift; 0 = bypass
NOTE_DIV, 31, divisor from filtered ch0 distance to note index

Ports:
clk_100MHz  in  1  system clock
reset  in  1  synchronous, active-high
echo_in  in  N_CH  asynchronous echo lines, bit i = channel i
trig_out  out  N_CH  trigger pulses, one-hot or zero
distance_cm  out  N_CH*DIST_W  filtered distance, channel i at [i*DIST_W +: DIST_W]
dist_valid  out  N_CH  1-cycle strobe per completed channel measurement
timeout  out  N_CH  sticky-per-measurement flag: last measurement of channel i timed out
active_ch  out  3  channel currently in its slot
speaker_note  out  5  filtered ch0 distance / NOTE_DIV, saturated at 31

Behaviour:
- Reset (synchronous, active-high; clock clk_100MHz): all outputs 0; FSM to IDLE; active_ch=0; slot counter 0; filter "primed" bits cleared; synchronisers cleared. Reset mid-measurement aborts it immediately; trig_out drops on the same edge.
- echo_in passes through a 2-FF synchroniser per bit. Edge detection uses the synchronised value and its 1-cycle delayed copy. Only channel active_ch is observed; echoes on other channels are ignored.
- FSM states: IDLE -> TRIG -> WAIT_RISE -> MEASURE -> HOLDOFF -> IDLE.
  - IDLE: one cycle; clear slot counter; go to TRIG.
  - TRIG: trig_out[active_ch]=1 for exactly TRIG_CYC cycles; go to WAIT_RISE.
  - WAIT_RISE: only a synchronised rising edge advances to MEASURE; an echo already high on entry is not accepted. If RISE_TO_CYC cycles elapse first, record a timeout and go to HOLDOFF.
  - MEASURE: a cycle counter wraps at CM_CYC-1, and each wrap increments cm_raw. cm_raw is the number of completed centimetres (truncated).
    - Synchronised falling edge -> record result and go to HOLDOFF.
    - cm_raw reaching MAX_CM+1 -> record a timeout and go to HOLDOFF immediately; the echo fall is not awaited.
  - HOLDOFF: wait until the slot counter reaches SLOT_CYC-1. Then active_ch increments, wrapping N_CH-1 -> 0, and the FSM returns to IDLE. The slot period is exact: trigger rises are SLOT_CYC+1 cycles apart (+1 for IDLE).
- Record result: on the cycle after the falling edge is detected, dist_valid[ch] pulses and timeout[ch]=0. distance_cm slice <= filtered value on that same cycle.
- Record timeout: dist_valid[ch] pulses, timeout[ch]=1, and the distance slice holds its previous value. The filter is not updated.
- Filter per channel:
  - First valid sample after reset loads directly and sets primed.
  - Thereafter f <= f + ((raw - f) >>> FILT_SHIFT), using signed DIST_W+1 arithmetic with truncation toward minus infinity.
  - FILT_SHIFT=0 means f = raw.
- speaker_note: registered, updated one cycle after distance slice 0 changes; min(f0 / NOTE_DIV, 31).
- Single-channel build (N_CH=1): active_ch is constant 0; slots repeat on channel 0.

Test Plan:
(All with CM_CYC=10, TRIG_CYC=5, SLOT_CYC=2000, RISE_TO_CYC=200, MAX_CM=50, NOTE_DIV=31 and default N_CH=2 unless noted.)
- Reset release, no echo -> trig_out[0] high exactly 5 cycles. trig_out[1] rises 2001 cycles after trig_out[0] rose. Neither is ever high simultaneously.
- FILT_SHIFT=0, ch0 echo high 257 cycles, 50 cycles after trigger fall -> dist_valid[0] pulse, slice0=25, timeout[0]=0, speaker_note=0.
- No echo on ch1 -> dist_valid[1] pulses 200 cycles after trigger fall; timeout[1]=1; slice1 unchanged (0).
- ch0 echo held high 700 cycles -> timeout[0]=1 when cm_raw reaches 51, before the echo falls; slice0 retains the prior value. The echo remaining high into the next slot is not accepted as a rise.
- FILT_SHIFT=2, ch0 samples 40 then 0 -> slice0 = 40, then 30; speaker_note = 1, then 0.
- Reset asserted mid-MEASURE on ch1 -> next edge: trig_out=0, outputs 0, active_ch=0. After release, a normal 25 cm measurement on ch0 loads unfiltered (re-primed).
